sum_drain_fifo: RTL
===================

// Module: sum_drain_fifo
// PURPOSE
//   Downstream stage of the sum-every-3 datapath: captures each sum pulsed out of the summer (dval + data, no backpressure).
//   Buffers sums in a DEPTH-entry FIFO and presents them on a valid/ready port to the consumer.
//   The summer cannot stall, so sums arriving while the FIFO is full are dropped and counted; a sticky flag records the loss.
// PARAMETERS
//   DW     12  width of one sum (summer input width + 2)
//   DEPTH  4   FIFO entries; power of two, >= 2
//   CW     16  width of saturating drop counter
// PORTS
//   clk       in   1                  clock, all state on posedge
//   rst       in   1                  reset, asynchronous, active-high
//   i_dval    in   1                  sum valid from summer, single-cycle pulses, may be back-to-back
//   i         in   DW                 sum data, sampled when i_dval=1
//   o_valid   out  1                  head entry available
//   o_ready   in   1                  consumer accepts head this cycle
//   o         out  DW                 head entry data; 0 when o_valid=0
//   o_count   out  $clog2(DEPTH+1)    current occupancy, 0..DEPTH
//   ovf       out  1                  sticky: >=1 sum dropped since reset/clear
//   drop_cnt  out  CW                 dropped sums, saturates at 2^CW-1
//   clr       in   1                  sync pulse: clear ovf and drop_cnt only
// BEHAVIOUR
//   Reset (rst=1, async): wr_ptr=rd_ptr=0, o_count=0, o_valid=0, o=0, ovf=0, drop_cnt=0; storage contents don't care.
//   pop  = o_valid & o_ready.
//   push = i_dval & (o_count<DEPTH | pop).
//     Full with simultaneous pop: slot freed same cycle, write accepted.
//   drop = i_dval & ~push (full, no pop).
//   Latency: sum with i_dval at edge N -> o_valid=1 and o=that sum after edge N (first-word fall-through, 1 cycle).
//   o, o_valid: combinational from registered state (mem[rd_ptr], o_count!=0); no combinational path from i_dval or o_ready.
//   o_count next = o_count + push - pop; push&pop leaves count unchanged (incl. at DEPTH).
//   Pointers: log2(DEPTH) bits, wrap naturally DEPTH-1 -> 0; full/empty from o_count, not ptr compare.
//   Ordering: strict FIFO; dropped sums never appear on o.
//   o_valid stays high while unpopped; o held stable until popped (valid/ready rules, consumer may stall indefinitely).
//   ovf: set on drop, held until clr; clr & drop same cycle -> ovf=1.
//   drop_cnt: +1 per drop, saturates at 2^CW-1; clr & drop same cycle -> drop_cnt=1.
//   clr does not touch FIFO contents, pointers or o_count.
//   rst mid-stream: all buffered sums discarded; first push after rst deasserts lands in slot 0.
// STRUCTURE
//   Package sum_pkg: localparam DW; typedef logic [DW-1:0] sum_t; drop-counter width CW.
//     sum_t shared with the summer.
//   Sub-module sat_counter #(W) (clk, rst, inc, clr, q): saturating counter, clr+inc -> 1.
//     Instantiated once for drop_cnt.
//   FIFO pointers, occupancy and storage array stay inline.
// TESTING
//   1. Single sum 7 with o_ready=1 -> o_valid high exactly 1 cycle after i_dval, o=7, o_count returns to 0.
//   2. o_ready=0, push 1,2,3,4 -> o_count=4; then o_ready=1 -> o=1,2,3,4 on consecutive cycles; ovf=0.
//   3. Full, o_ready=0, push 5,6 -> drop_cnt=2, ovf=1; drain yields 1,2,3,4 only.
//   4. Full, i_dval=1 (value 9) with o_ready=1 same cycle -> no drop, o_count stays 4; 9 emerges last.
//   5. CW=4, 20 drops -> drop_cnt=15 held; clr together with a drop -> drop_cnt=1, ovf=1; clr alone -> 0/0.
//   6. rst pulse asserted with 3 entries buffered, async mid-cycle -> o_valid=0, o=0, o_count=0 immediately.
//      Next push 11 -> o=11.

Source files
------------

// File: rtl/sum_pkg.sv
// Shared types and widths for the sum-every-3 datapath.
package sum_pkg;

   localparam int unsigned DW = 12;
   localparam int unsigned CW = 16;

   typedef logic [DW-1:0] sum_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; a clear coinciding with an increment restarts at 1.
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= '0;
      end else if (clr) begin
         q <= inc ? W'(1) : '0;
      end else if (inc && (q != {W{1'b1}})) begin
         q <= q + W'(1);
      end
   end

endmodule

// File: rtl/sum_drain_fifo.sv
// Buffers summer output in a first-word-fall-through FIFO; overflowing sums are dropped and counted.
module sum_drain_fifo #(
   parameter int unsigned DW    = sum_pkg::DW,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CW    = sum_pkg::CW
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_dval,
   input  logic [DW-1:0]              i,
   output logic                       o_valid,
   input  logic                       o_ready,
   output logic [DW-1:0]              o,
   output logic [$clog2(DEPTH+1)-1:0] o_count,
   output logic                       ovf,
   output logic [CW-1:0]              drop_cnt,
   input  logic                       clr
);

   import sum_pkg::*;

   localparam int unsigned AW  = $clog2(DEPTH);
   localparam int unsigned CNW = $clog2(DEPTH+1);

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          pop;
   logic          push;
   logic          drop;

   // A pop in the same cycle frees a slot, so a full FIFO still accepts.
   always_comb begin
      pop  = o_valid & o_ready;
      push = i_dval & ((o_count < CNW'(DEPTH)) | pop);
      drop = i_dval & ~push;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         o_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         o_count <= o_count + CNW'(push) - CNW'(pop);
      end
   end

   // Storage needs no reset; occupancy gates visibility.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= i;
   end

   always_comb begin
      o_valid = (o_count != '0);
      o       = o_valid ? mem[rd_ptr] : '0;
   end

   // Drop wins over clear so a loss in the clearing cycle is never hidden.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf <= 1'b0;
      end else if (drop) begin
         ovf <= 1'b1;
      end else if (clr) begin
         ovf <= 1'b0;
      end
   end

   sat_counter #(.W(CW)) u_drop_cnt (
      .clk (clk),
      .rst (rst),
      .inc (drop),
      .clr (clr),
      .q   (drop_cnt)
   );

endmodule
